// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition unit: condition codes, NZCV layout
// and the flag-write group bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_flags_unit_check.sv
// ConditionCheck: purely combinational evaluation of a 4-bit condition field
// against the NZCV flags.
module ConditionCheck
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  nzcv_t      flags_i,
  output logic       cond_ex_o
);

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_e'(cond_i))
      EQ: cond_ex_o = flags_i.z;
      NE: cond_ex_o = ~flags_i.z;
      CS: cond_ex_o = flags_i.c;
      CC: cond_ex_o = ~flags_i.c;
      MI: cond_ex_o = flags_i.n;
      PL: cond_ex_o = ~flags_i.n;
      VS: cond_ex_o = flags_i.v;
      VC: cond_ex_o = ~flags_i.v;
      HI: cond_ex_o = flags_i.c & ~flags_i.z;
      LS: cond_ex_o = ~flags_i.c | flags_i.z;
      GE: cond_ex_o = ~(flags_i.n ^ flags_i.v);
      LT: cond_ex_o = flags_i.n ^ flags_i.v;
      GT: cond_ex_o = ~flags_i.z & ~(flags_i.n ^ flags_i.v);
      LE: cond_ex_o = flags_i.z | (flags_i.n ^ flags_i.v);
      AL: cond_ex_o = 1'b1;
      NV: cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// Execute-stage condition unit: NZCV register, condition gating of PCS/RegW/MemW
// into the M stage, and saturating executed/skipped counters.
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_w_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  input  logic             cnt_clr_i,
  output logic [3:0]       flags_o,
  output logic             cond_ex_o,
  output logic             valid_o,
  output logic             pcs_o,
  output logic             reg_w_o,
  output logic             mem_w_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] skip_cnt_o
);

  nzcv_t            flags_q, flags_d;
  logic             valid_q, pcs_q, reg_w_q, mem_w_q;
  logic [CNT_W-1:0] exec_q, exec_d, skip_q, skip_d;
  logic             raw_ex, cond_ex, adv, clr;

  ConditionCheck u_check (
    .cond_i    (cond_i),
    .flags_i   (flags_q),
    .cond_ex_o (raw_ex)
  );

  // Reserved code is masked here as well so the result never depends on the evaluator's default.
  assign cond_ex = valid_i & raw_ex & (cond_i != 4'(NV));
  assign adv     = ~stall_i & ~flush_i & valid_i;
  assign clr     = cnt_clr_i & ~stall_i;

  always_comb begin
    flags_d = flags_q;
    if (adv && cond_ex) begin
      if (flag_w_i[FLAGW_NZ]) {flags_d.n, flags_d.z} = alu_flags_i[3:2];
      if (flag_w_i[FLAGW_CV]) {flags_d.c, flags_d.v} = alu_flags_i[1:0];
    end
  end

  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (clr) begin
      exec_d = '0;
      skip_d = '0;
    end else if (adv) begin
      if (cond_ex && (exec_q != '1)) exec_d = exec_q + CNT_W'(1);
      if (!cond_ex && (skip_q != '1)) skip_d = skip_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= nzcv_t'(RESET_FLAGS);
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pcs_q   <= 1'b0;
      reg_w_q <= 1'b0;
      mem_w_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pcs_q   <= 1'b0;
      reg_w_q <= 1'b0;
      mem_w_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      pcs_q   <= pcs_i & cond_ex;
      reg_w_q <= reg_w_i & cond_ex & ~no_write_i;
      mem_w_q <= mem_w_i & cond_ex;
    end
  end

  assign flags_o    = flags_q;
  assign cond_ex_o  = cond_ex;
  assign valid_o    = valid_q;
  assign pcs_o      = pcs_q;
  assign reg_w_o    = reg_w_q;
  assign mem_w_o    = mem_w_q;
  assign exec_cnt_o = exec_q;
  assign skip_cnt_o = skip_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit with an architectural reference model and
// per-cycle comparison, plus literal expectations from hand-worked scenarios.
module tb_cond_flags_unit;

  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic stall_i = 0, flush_i = 0, valid_i = 0, pcs_i = 0, reg_w_i = 0, mem_w_i = 0;
  logic no_write_i = 0, cnt_clr_i = 0;
  logic [3:0] cond_i = 4'hE, alu_flags_i = 4'h0, flags_o;
  logic [1:0] flag_w_i = 2'b00;
  logic cond_ex_o, valid_o, pcs_o, reg_w_o, mem_w_o;
  logic [CNT_W-1:0] exec_cnt_o, skip_cnt_o;

  int errors = 0;
  int checks = 0;

  cond_flags_unit #(.CNT_W(CNT_W), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .cond_i(cond_i), .flag_w_i(flag_w_i), .alu_flags_i(alu_flags_i), .pcs_i(pcs_i),
    .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .no_write_i(no_write_i), .cnt_clr_i(cnt_clr_i),
    .flags_o(flags_o), .cond_ex_o(cond_ex_o), .valid_o(valid_o), .pcs_o(pcs_o),
    .reg_w_o(reg_w_o), .mem_w_o(mem_w_o), .exec_cnt_o(exec_cnt_o), .skip_cnt_o(skip_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural truth table for the condition field, flags as {N,Z,C,V}.
  function automatic bit ev(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0] mflags;
  bit mv, mpcs, mregw, mmemw;
  int mexec, mskip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mflags = 4'b0000; mv = 0; mpcs = 0; mregw = 0; mmemw = 0; mexec = 0; mskip = 0;
    end else begin
      bit ce, go;
      ce = valid_i && ev(cond_i, mflags);
      go = !stall_i && !flush_i && valid_i;
      if (!stall_i) begin
        if (cnt_clr_i) begin
          mexec = 0; mskip = 0;
        end else if (go) begin
          if (ce) mexec = (mexec < CMAX) ? mexec + 1 : CMAX;
          else    mskip = (mskip < CMAX) ? mskip + 1 : CMAX;
        end
      end
      if (go && ce) begin
        if (flag_w_i[1]) mflags[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0]) mflags[1:0] = alu_flags_i[1:0];
      end
      if (flush_i) begin
        mv = 0; mpcs = 0; mregw = 0; mmemw = 0;
      end else if (!stall_i) begin
        mv = valid_i; mpcs = pcs_i && ce; mregw = reg_w_i && ce && !no_write_i; mmemw = mem_w_i && ce;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_flags", 32'(flags_o), 32'(mflags));
    chk("m_cond_ex", 32'(cond_ex_o), 32'(valid_i && ev(cond_i, mflags)));
    chk("m_valid", 32'(valid_o), 32'(mv));
    chk("m_pcs", 32'(pcs_o), 32'(mpcs));
    chk("m_reg_w", 32'(reg_w_o), 32'(mregw));
    chk("m_mem_w", 32'(mem_w_o), 32'(mmemw));
    chk("m_exec", 32'(exec_cnt_o), 32'(mexec));
    chk("m_skip", 32'(skip_cnt_o), 32'(mskip));
  end

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                       input logic p, input logic rw, input logic mw, input logic nw);
    valid_i = 1; cond_i = c; flag_w_i = fw; alu_flags_i = alu;
    pcs_i = p; reg_w_i = rw; mem_w_i = mw; no_write_i = nw;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flags", 32'(flags_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_exec", 32'(exec_cnt_o), 32'h0);
    rst_n = 1'b1;

    drive(4'hE, 2'b11, 4'b1010, 0, 0, 0, 0);
    chk("al_cond_ex", 32'(cond_ex_o), 32'h1);
    tick();
    chk("al_flags", 32'(flags_o), 32'hA);
    chk("al_exec", 32'(exec_cnt_o), 32'h1);

    drive(4'hE, 2'b11, 4'b0100, 0, 0, 0, 0); tick();
    drive(4'h1, 2'b11, 4'b1111, 0, 1, 0, 0);
    chk("ne_cond_ex", 32'(cond_ex_o), 32'h0);
    tick();
    chk("ne_reg_w", 32'(reg_w_o), 32'h0);
    chk("ne_skip", 32'(skip_cnt_o), 32'h1);
    chk("ne_flags", 32'(flags_o), 32'h4);

    drive(4'hE, 2'b11, 4'b0000, 0, 0, 0, 0); tick();
    drive(4'hE, 2'b10, 4'b1111, 0, 0, 0, 0); tick();
    chk("nz_only", 32'(flags_o), 32'hC);
    drive(4'hE, 2'b01, 4'b0011, 0, 0, 0, 0); tick();
    chk("cv_only", 32'(flags_o), 32'hF);

    drive(4'hE, 2'b11, 4'b0100, 0, 1, 0, 1); tick();
    chk("cmp_reg_w", 32'(reg_w_o), 32'h0);
    chk("cmp_flags", 32'(flags_o), 32'h4);
    drive(4'h0, 2'b00, 4'b0000, 1, 1, 1, 0);
    chk("eq_cond_ex", 32'(cond_ex_o), 32'h1);
    tick();
    chk("eq_pcs", 32'(pcs_o), 32'h1);
    chk("exec_sat", 32'(exec_cnt_o), 32'h3);

    stall_i = 1;
    drive(4'hE, 2'b11, 4'b1001, 0, 0, 1, 0);
    repeat (3) tick();
    chk("stall_flags", 32'(flags_o), 32'h4);
    chk("stall_mem_w", 32'(mem_w_o), 32'h1);
    flush_i = 1; tick();
    chk("flush_valid", 32'(valid_o), 32'h0);
    chk("flush_exec", 32'(exec_cnt_o), 32'h3);
    stall_i = 0; tick();
    chk("flush_only_flags", 32'(flags_o), 32'h4);
    flush_i = 0;

    cnt_clr_i = 1; drive(4'hE, 2'b00, 4'h0, 0, 0, 0, 0); tick();
    chk("clr_exec", 32'(exec_cnt_o), 32'h0);
    chk("clr_skip", 32'(skip_cnt_o), 32'h0);
    cnt_clr_i = 0;
    stall_i = 1; cnt_clr_i = 1; tick();
    cnt_clr_i = 0; stall_i = 0;

    for (int f = 0; f < 16; f++) begin
      drive(4'hE, 2'b11, 4'(f), 0, 0, 0, 0); tick();
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 2'b00, 4'hF, 1, 1, 1, (c % 3) == 0);
        tick();
      end
      valid_i = 0; tick();
      if (f == 5) begin cnt_clr_i = 1; tick(); cnt_clr_i = 0; end
    end

    drive(4'hE, 2'b11, 4'b1011, 1, 1, 1, 0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", 32'(flags_o), 32'h0);
    chk("arst_valid", 32'(valid_o | pcs_o | reg_w_o | mem_w_o), 32'h0);
    chk("arst_cnt", 32'(exec_cnt_o | skip_cnt_o), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(4'hF, 2'b11, 4'hF, 1, 1, 1, 0); tick();
    chk("nv_skip", 32'(skip_cnt_o), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
